id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble insertion.
- Sits between decode/register-read and execute.
- Lets EX back-pressure ID without a combinational ready path, and lets branch/hazard logic squash in-flight instructions.
- Splits the EX control word into RegDst/AluOp/AluSrc and extracts the funct field for ALU control.

Parameters:
- DATA_W, 32, width of PC+4, register read data and immediate
- REG_W, 5, register-specifier width
- WB_W, 2, write-back control width
- M_W, 2, memory control width
- FUNCT_W, 6, width of funct field taken from imm[FUNCT_W-1:0]

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID presents a valid instruction
- in_ready  out  1  register can accept this cycle
- out_valid  out  1  EX-side outputs hold a valid instruction
- out_ready  in  1  EX consumes the instruction this cycle
- flush  in  1  squash all held and incoming instructions
- wb_ctrl / m_ctrl  in  WB_W / M_W  control fields
- ex_ctrl  in  4  bit0 RegDst, bits2:1 AluOp, bit3 AluSrc
- branch  in  1  branch flag
- pc_plus_four, rd1, rd2, imm  in  DATA_W each  datapath values
- rs, rt, rt_extra, rd  in  REG_W each  register specifiers
- wb_ctrl_q / m_ctrl_q  out  WB_W / M_W  registered control fields
- reg_dst, alu_src  out  1  decoded from ex_ctrl
- alu_op  out  2  decoded from ex_ctrl
- branch_q  out  1  registered branch flag
- pc_plus_four_q, rd1_q, rd2_q, imm_q  out  DATA_W  registered data
- funct  out  FUNCT_W  imm[FUNCT_W-1:0] of held instruction
- rs_q, rt_q, rt_extra_q, rd_q  out  REG_W  registered specifiers

Behaviour:
- Storage: main entry (drives outputs) plus skid entry; each has a valid bit.
- in_ready = !skid_valid && !rst; it is a register output only, with no combinational path from out_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready. out_valid = main_valid.
- Per rising edge, no flush/rst:
  - main empty or draining, skid empty: accepted data loads into main.
  - main full and not draining, accepting: data loads into skid; in_ready drops to 0 next cycle.
  - draining with skid full: skid moves to main, skid clears. Accept is impossible because in_ready=0.
  - draining, nothing accepted, skid empty: main_valid clears.
  - not draining: main holds all fields unchanged, i.e. stall.
- Latency: 1 cycle from accept to out_valid when empty. Full throughput of 1/cycle with out_ready held high.
- Ordering is strictly FIFO, so the skid entry always leaves before newer data.
- Bubble: when main_valid=0, wb_ctrl_q, m_ctrl_q, reg_dst, alu_op, alu_src and branch_q are forced to 0. Data and specifier outputs hold their last value.
- Flush: main_valid and skid_valid clear next cycle. Control fields of both entries go to 0. An input offered in the flush cycle is dropped. in_ready=1 the cycle after flush.
- rst: every output register goes to 0, both valids go to 0, and in_ready=0 while rst is high. rst has priority over flush and handshake; reset mid-stall discards both entries.
- flush and drain in the same cycle: the drain completes (EX saw it) and the flush clears the rest.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> all outputs 0, in_ready=0 during rst, out_valid=0. Release -> in_ready=1.
- Streaming: out_ready=1; send imm=0x0000_0020, then 0x0000_0022, then 0x0000_0024 on consecutive cycles with ex_ctrl=4'b0101 -> each appears 1 cycle later with funct=0x20/0x22/0x24, reg_dst=1, alu_op=2'b10, alu_src=0, no gaps.
- Back-pressure: out_ready=0, send A (pc=0x4) then B (pc=0x8) -> in_ready=0 after B, outputs hold A. Raise out_ready -> A then B emitted in order, in_ready returns 1.
- Flush: main=A and skid=B, assert flush while offering C -> next cycle out_valid=0, wb_ctrl_q=0, branch_q=0, in_ready=1; C is never emitted.
- Bubble: stop in_valid after one instruction with wb_ctrl=2'b11, m_ctrl=2'b01 -> after drain, control outputs read 0 while rd1_q keeps its last value (e.g. 0xDEAD_BEEF).
- Parametrisation: DATA_W=64, REG_W=6 -> a 64-bit imm=0x1_0000_003F passes intact, funct=0x3F.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX pipeline register bus. The master side is the decode stage plus the EX
// consumer (drives the instruction, out_ready and flush). The slave side is the
// pipeline register itself.
interface id_ex_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int WB_W    = 2,
    parameter int M_W     = 2,
    parameter int FUNCT_W = 6
);
    // handshake and squash
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               flush;

    // incoming instruction from ID
    logic [WB_W-1:0]    wb_ctrl;
    logic [M_W-1:0]     m_ctrl;
    logic [3:0]         ex_ctrl;
    logic               branch;
    logic [DATA_W-1:0]  pc_plus_four;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rt_extra;
    logic [REG_W-1:0]   rd;

    // held instruction toward EX
    logic [WB_W-1:0]    wb_ctrl_q;
    logic [M_W-1:0]     m_ctrl_q;
    logic               reg_dst;
    logic [1:0]         alu_op;
    logic               alu_src;
    logic               branch_q;
    logic [DATA_W-1:0]  pc_plus_four_q;
    logic [DATA_W-1:0]  rd1_q;
    logic [DATA_W-1:0]  rd2_q;
    logic [DATA_W-1:0]  imm_q;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rs_q;
    logic [REG_W-1:0]   rt_q;
    logic [REG_W-1:0]   rt_extra_q;
    logic [REG_W-1:0]   rd_q;

    modport master (
        output in_valid, out_ready, flush,
        output wb_ctrl, m_ctrl, ex_ctrl, branch,
        output pc_plus_four, rd1, rd2, imm, rs, rt, rt_extra, rd,
        input  in_ready, out_valid,
        input  wb_ctrl_q, m_ctrl_q, reg_dst, alu_op, alu_src, branch_q,
        input  pc_plus_four_q, rd1_q, rd2_q, imm_q, funct,
        input  rs_q, rt_q, rt_extra_q, rd_q
    );

    modport slave (
        input  in_valid, out_ready, flush,
        input  wb_ctrl, m_ctrl, ex_ctrl, branch,
        input  pc_plus_four, rd1, rd2, imm, rs, rt, rt_extra, rd,
        output in_ready, out_valid,
        output wb_ctrl_q, m_ctrl_q, reg_dst, alu_op, alu_src, branch_q,
        output pc_plus_four_q, rd1_q, rd2_q, imm_q, funct,
        output rs_q, rt_q, rt_extra_q, rd_q
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid
// buffer. in_ready depends only on local state (skid occupancy and rst), so
// EX back-pressure never forms a combinational path back into ID. Flush
// squashes both entries; an empty main entry presents a bubble (control
// fields forced to zero, data fields keep their last value).
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int WB_W    = 2,
    parameter int M_W     = 2,
    parameter int FUNCT_W = 6
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);

    // One stored instruction. ex holds the raw EX control word:
    // bit0 RegDst, bits2:1 AluOp, bit3 AluSrc.
    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [3:0]        ex;
        logic              br;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rt_extra;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t in_e;
    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;
    logic   main_free;

    // A squashed entry keeps its datapath values but loses every control bit,
    // so nothing downstream can act on it even if it leaked through.
    function automatic entry_t strip_ctrl(input entry_t e);
        entry_t r;
        r    = e;
        r.wb = '0;
        r.m  = '0;
        r.ex = '0;
        r.br = 1'b0;
        return r;
    endfunction

    // Pack the incoming instruction into one entry.
    always_comb begin
        in_e          = '0;
        in_e.wb       = bus.wb_ctrl;
        in_e.m        = bus.m_ctrl;
        in_e.ex       = bus.ex_ctrl;
        in_e.br       = bus.branch;
        in_e.pc       = bus.pc_plus_four;
        in_e.rd1      = bus.rd1;
        in_e.rd2      = bus.rd2;
        in_e.imm      = bus.imm;
        in_e.rs       = bus.rs;
        in_e.rt       = bus.rt;
        in_e.rt_extra = bus.rt_extra;
        in_e.rd       = bus.rd;
    end

    // Ready only from the skid flag and reset: no out_ready in this cone.
    assign bus.in_ready = !skid_valid && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = main_valid && bus.out_ready;
    // Main may take new data this edge when it is empty or being consumed.
    assign main_free    = !main_valid || drain;

    // Main entry: refilled from skid first (FIFO order), else from input.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_q     <= '0;
        end else if (bus.flush) begin
            // A drain in this cycle already completed at EX; the rest is squashed.
            main_valid <= 1'b0;
            main_q     <= strip_ctrl(main_q);
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
            end else if (accept) begin
                main_q     <= in_e;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end
    end

    // Skid entry: catches the one instruction accepted while main stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            skid_valid <= 1'b0;
            skid_q     <= strip_ctrl(skid_q);
        end else if (main_free) begin
            // Skid (if any) moves into main this edge; accept cannot coincide.
            skid_valid <= 1'b0;
        end else if (accept) begin
            skid_q     <= in_e;
            skid_valid <= 1'b1;
        end
    end

    // Output decode with bubble gating on the control fields.
    always_comb begin
        bus.out_valid = main_valid;
        bus.wb_ctrl_q = '0;
        bus.m_ctrl_q  = '0;
        bus.reg_dst   = 1'b0;
        bus.alu_op    = 2'b00;
        bus.alu_src   = 1'b0;
        bus.branch_q  = 1'b0;
        if (main_valid) begin
            bus.wb_ctrl_q = main_q.wb;
            bus.m_ctrl_q  = main_q.m;
            bus.reg_dst   = main_q.ex[0];
            bus.alu_op    = main_q.ex[2:1];
            bus.alu_src   = main_q.ex[3];
            bus.branch_q  = main_q.br;
        end
    end

    // Datapath and specifiers come straight from main and are never gated.
    assign bus.pc_plus_four_q = main_q.pc;
    assign bus.rd1_q          = main_q.rd1;
    assign bus.rd2_q          = main_q.rd2;
    assign bus.imm_q          = main_q.imm;
    assign bus.funct          = main_q.imm[FUNCT_W-1:0];
    assign bus.rs_q           = main_q.rs;
    assign bus.rt_q           = main_q.rt;
    assign bus.rt_extra_q     = main_q.rt_extra;
    assign bus.rd_q           = main_q.rd;

endmodule
